modexp_arbiter: RTL and testbench
=================================

MODEXP_ARBITER -- requirements
Module: modexp_arbiter

Interface
REQ-001 SHALL have parameter N_W, default 8, giving the modulus, base and result width.
REQ-002 SHALL have parameter E_W, default 9, giving the exponent width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 2, with one bit per requester: port 0 is encrypt, port 1 is decrypt.
REQ-006 SHALL have port req_ready, output, 2, the per-requester accept signal.
REQ-007 SHALL have ports req_base0/req_base1, input, N_W each, the message or ciphertext.
REQ-008 SHALL have ports req_exp0/req_exp1, input, E_W each, holding e or d.
REQ-009 SHALL have ports req_mod0/req_mod1, input, N_W each, holding the modulus n.
REQ-010 SHALL have port rsp_valid, output, 1, signalling that a result is available.
REQ-011 SHALL have port rsp_ready, input, 1, the consumer accept signal.
REQ-012 SHALL have port rsp_id, output, 1, identifying the requester that owns the result.
REQ-013 SHALL have port rsp_data, output, N_W, carrying base^exp mod n.
REQ-014 SHALL have port rsp_err, output, 1, set when the captured modulus was 0.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-017 SHALL assert req_ready[i] only in IDLE, only for the granted port, and combinationally from req_valid; at most one bit is ever high.
REQ-018 SHALL arbitrate round-robin: with one port valid, that port is granted; with both valid, the port not granted last time is granted.
REQ-019 SHALL reset the last-grant pointer to 1, so port 0 wins the first contention.
REQ-020 SHALL, on accept (valid & ready, cycle T), capture base mod n, exp, n and id, set acc = 1 mod n, and move IDLE->CALC.
REQ-021 SHALL, in CALC, process one exponent bit per cycle LSB-first, for exactly E_W cycles (T+1..T+E_W): if the bit is 1 then acc = acc*b mod n; then b = b*b mod n; both products are formed at 2*N_W width before reduction.
REQ-022 SHALL move CALC->DONE after the final bit and assert rsp_valid at cycle T+E_W+1, with rsp_data, rsp_id and rsp_err registered and stable.
REQ-023 SHALL hold rsp_valid and all response fields until rsp_valid & rsp_ready, then return DONE->IDLE on the next edge.
REQ-024 SHALL allow a new accept no earlier than the cycle after returning to IDLE, giving a minimum of E_W+3 cycles between accepts.
REQ-025 SHALL NOT accept requests during CALC or DONE; requesters hold valid and data stable until accepted.
REQ-026 SHALL handle modulus boundaries as follows: n=0 gives rsp_err=1 and rsp_data=0, still after the full latency; n=1 gives rsp_data=0 and rsp_err=0.
REQ-027 SHALL return 1 mod n for exponent 0.
REQ-028 SHALL ignore any base ≥ n beyond the reduction already performed at capture.
REQ-029 SHALL leave the arbitration pointer unchanged when rsp_ready is asserted with rsp_valid low.

Reset
REQ-030 SHALL, on synchronous rst=1, force state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0 and last-grant=1.
REQ-031 SHALL abort any operation in progress on reset mid-CALC or mid-DONE, with no response ever emitted for it.
REQ-032 SHALL keep req_ready low during any cycle in which rst is high.

Structure
REQ-033 SHALL place N_W/E_W defaults and the state enum type in shared package rsa_pkg.
REQ-034 SHALL use one combinational sub-module, mod_mul (a*b mod n at 2*N_W width, returning 0 for n=0), instantiated twice: once for the multiply and once for the square.

Verification
REQ-035 SHALL verify: port0 base=7, exp=3, n=33 -> rsp_data=13, rsp_id=0, rsp_valid rises exactly 10 cycles after accept.
REQ-036 SHALL verify: port1 base=13, exp=7, n=33 -> rsp_data=7, rsp_id=1, confirming an encrypt/decrypt round trip.
REQ-037 SHALL verify: both ports valid from reset -> grants in order 0, 1, 0, 1 across four back-to-back jobs, with rsp_ready tied high.
REQ-038 SHALL verify: rsp_ready held low for 5 cycles in DONE -> rsp_valid and rsp_data=12 (base 3, exp 7, n 15) held stable, and no new grant.
REQ-039 SHALL verify: boundaries -> exp=0, n=15 gives 1; n=1 gives 0; n=0 gives rsp_err=1 and data 0.
REQ-040 SHALL verify: rst pulsed at cycle T+4 of a job -> no rsp_valid, busy=0 the next cycle, and the next request is accepted normally.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared defaults and FSM state type for the modular-exponentiation arbiter.
package rsa_pkg;

  localparam int N_W_DEF = 8;
  localparam int E_W_DEF = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mod_mul.sv
// Combinational modular multiply: p = (a * b) mod n, formed at double width; n = 0 yields 0.
module mod_mul #(
  parameter int N_W = 8
) (
  input  logic [N_W-1:0] a,
  input  logic [N_W-1:0] b,
  input  logic [N_W-1:0] n,
  output logic [N_W-1:0] p
);

  logic [2*N_W-1:0] prod_s;
  logic [2*N_W-1:0] n_ext_s;
  logic [2*N_W-1:0] rem_s;

  assign prod_s  = {{N_W{1'b0}}, a} * {{N_W{1'b0}}, b};
  assign n_ext_s = {{N_W{1'b0}}, n};
  assign rem_s   = (n == {N_W{1'b0}}) ? {(2*N_W){1'b0}} : (prod_s % n_ext_s);
  assign p       = rem_s[N_W-1:0];

endmodule

// File: rtl/modexp_arbiter.sv
// Two-requester round-robin front end for a bit-serial square-and-multiply
// modular exponentiator (LSB-first, one exponent bit per cycle).
module modexp_arbiter
  import rsa_pkg::*;
#(
  parameter int N_W = N_W_DEF,
  parameter int E_W = E_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [N_W-1:0] req_base0,
  input  logic [N_W-1:0] req_base1,
  input  logic [E_W-1:0] req_exp0,
  input  logic [E_W-1:0] req_exp1,
  input  logic [N_W-1:0] req_mod0,
  input  logic [N_W-1:0] req_mod1,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [N_W-1:0] rsp_data,
  output logic           rsp_err,
  output logic           busy
);

  localparam int CW = $clog2(E_W + 1);

  state_e         state_q, state_d;
  logic           last_q, last_d;
  logic           hold_q, hold_d;
  logic [N_W-1:0] base_q, base_d;
  logic [E_W-1:0] exp_q, exp_d;
  logic [N_W-1:0] mod_q, mod_d;
  logic [N_W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           id_q, id_d;
  logic           rsp_id_q, rsp_id_d;
  logic [N_W-1:0] rsp_data_q, rsp_data_d;
  logic           rsp_err_q, rsp_err_d;

  logic [1:0]     grant_s;
  logic [N_W-1:0] mul_s;
  logic [N_W-1:0] sq_s;
  logic [N_W-1:0] in_base_s;
  logic [E_W-1:0] in_exp_s;
  logic [N_W-1:0] in_mod_s;
  logic [N_W-1:0] in_red_s;
  logic [N_W-1:0] acc_next_s;

  localparam logic [N_W-1:0] ONE = {{(N_W-1){1'b0}}, 1'b1};

  mod_mul #(.N_W(N_W)) u_mul (.a(acc_q),  .b(base_q), .n(mod_q), .p(mul_s));
  mod_mul #(.N_W(N_W)) u_sq  (.a(base_q), .b(base_q), .n(mod_q), .p(sq_s));

  assign in_base_s = grant_s[1] ? req_base1 : req_base0;
  assign in_exp_s  = grant_s[1] ? req_exp1  : req_exp0;
  assign in_mod_s  = grant_s[1] ? req_mod1  : req_mod0;
  assign in_red_s  = (in_mod_s == {N_W{1'b0}}) ? {N_W{1'b0}} : (in_base_s % in_mod_s);
  assign acc_next_s = exp_q[0] ? mul_s : acc_q;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    hold_d     = hold_q;
    base_d     = base_q;
    exp_d      = exp_q;
    mod_d      = mod_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    grant_s    = 2'b00;
    case (state_q)
      ST_IDLE: begin
        hold_d = 1'b0;
        // The first IDLE cycle after a response is a dead cycle, no grant.
        if (!rst && !hold_q) begin
          case (req_valid)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = last_q ? 2'b01 : 2'b10;
            default: grant_s = 2'b00;
          endcase
        end else begin
          grant_s = 2'b00;
        end
        if (|(req_valid & grant_s)) begin
          state_d = ST_CALC;
          last_d  = grant_s[1];
          id_d    = grant_s[1];
          base_d  = in_red_s;
          exp_d   = in_exp_s;
          mod_d   = in_mod_s;
          acc_d   = (in_mod_s > ONE) ? ONE : {N_W{1'b0}};
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        acc_d  = acc_next_s;
        base_d = sq_s;
        exp_d  = {1'b0, exp_q[E_W-1:1]};
        cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(E_W - 1)) begin
          state_d    = ST_DONE;
          rsp_data_d = acc_next_s;
          rsp_id_d   = id_q;
          rsp_err_d  = (mod_q == {N_W{1'b0}});
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          hold_d  = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      hold_q     <= 1'b0;
      base_q     <= {N_W{1'b0}};
      exp_q      <= {E_W{1'b0}};
      mod_q      <= {N_W{1'b0}};
      acc_q      <= {N_W{1'b0}};
      cnt_q      <= {CW{1'b0}};
      id_q       <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= {N_W{1'b0}};
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      hold_q     <= hold_d;
      base_q     <= base_d;
      exp_q      <= exp_d;
      mod_q      <= mod_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign req_ready = grant_s;
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_modexp_arbiter.sv
// Self-checking bench for modexp_arbiter: vector table, scoreboard, and corner-case sequences.
module tb_modexp_arbiter;

  localparam int N_W = 8;
  localparam int E_W = 9;
  localparam int LAT = E_W + 1;
  localparam int GAP = E_W + 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [N_W-1:0] req_base0, req_base1, req_mod0, req_mod1;
  logic [E_W-1:0] req_exp0, req_exp1;
  logic           rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [N_W-1:0] rsp_data;

  modexp_arbiter #(.N_W(N_W), .E_W(E_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_base0(req_base0), .req_base1(req_base1),
    .req_exp0(req_exp0), .req_exp1(req_exp1),
    .req_mod0(req_mod0), .req_mod1(req_mod1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           id;
    logic [N_W-1:0] data;
    logic           err;
  } rsp_t;

  typedef struct {
    logic           port;
    logic [N_W-1:0] base;
    logic [E_W-1:0] exp;
    logic [N_W-1:0] mod;
    logic [N_W-1:0] data;
    logic           err;
  } vec_t;

  rsp_t sb[$];
  logic grants[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference by plain repeated multiplication.
  function automatic logic [N_W-1:0] ref_pow(input int b, input int e, input int n);
    int r;
    if (n == 0) return '0;
    r = 1 % n;
    for (int i = 0; i < e; i++) r = (r * (b % n)) % n;
    return N_W'(r);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard pops, latency, accept spacing, grant log.
  initial begin
    rsp_t e;
    int   acc_cyc;
    logic have_acc;
    logic prev_v;
    have_acc = 1'b0;
    prev_v = 1'b0;
    acc_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_acc = 1'b0;
        prev_v = 1'b0;
      end else begin
        if (|(req_valid & req_ready)) begin
          chk("ready_onehot_idle", {30'd0, busy, ($countones(req_ready) == 1)}, 32'd1);
          if (have_acc) chk("accept_gap_ok", (cyc - acc_cyc >= GAP) ? 32'd1 : 32'd0, 32'd1);
          grants.push_back(req_ready[1]);
          acc_cyc = cyc;
          have_acc = 1'b1;
        end
        if (rsp_valid && !prev_v) chk("latency", cyc - acc_cyc, LAT);
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
            chk("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          end
        end
        prev_v = rsp_valid;
      end
    end
  end

  task automatic drive(input logic p, input logic [N_W-1:0] b, input logic [E_W-1:0] e,
                       input logic [N_W-1:0] n);
    if (p) begin
      req_base1 = b; req_exp1 = e; req_mod1 = n;
    end else begin
      req_base0 = b; req_exp0 = e; req_mod0 = n;
    end
    req_valid[p] = 1'b1;
  endtask

  task automatic wait_acc(input logic p, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_valid[p] && req_ready[p]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (ok) req_valid[p] = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk(name, sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    grants.delete();
  endtask

  task automatic do_job(input logic p, input logic [N_W-1:0] b, input logic [E_W-1:0] e,
                        input logic [N_W-1:0] n, input logic [N_W-1:0] d, input logic er);
    logic ok;
    sb.push_back('{id: p, data: d, err: er});
    drive(p, b, e, n);
    wait_acc(p, ok);
    chk("job_accepted", {31'd0, ok}, 32'd1);
    if (!ok) begin
      req_valid[p] = 1'b0;
      void'(sb.pop_back());
    end
    wait_empty("job_response");
  endtask

  vec_t vt[10];

  initial begin
    logic ok;
    int   nv;
    vt[0] = '{1'b0, 8'd7,   9'd3,   8'd33,  8'd13,  1'b0};
    vt[1] = '{1'b1, 8'd13,  9'd7,   8'd33,  8'd7,   1'b0};
    vt[2] = '{1'b0, 8'd3,   9'd7,   8'd15,  8'd12,  1'b0};
    vt[3] = '{1'b1, 8'd5,   9'd0,   8'd15,  8'd1,   1'b0};
    vt[4] = '{1'b0, 8'd9,   9'd5,   8'd1,   8'd0,   1'b0};
    vt[5] = '{1'b1, 8'd9,   9'd5,   8'd0,   8'd0,   1'b1};
    vt[6] = '{1'b0, 8'd40,  9'd3,   8'd33,  8'd13,  1'b0};
    vt[7] = '{1'b1, 8'd2,   9'd511, 8'd255, 8'd128, 1'b0};
    vt[8] = '{1'b0, 8'd0,   9'd0,   8'd7,   8'd1,   1'b0};
    vt[9] = '{1'b1, 8'd255, 9'd256, 8'd254, 8'd1,   1'b0};

    rst = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    req_base0 = '0; req_base1 = '0; req_exp0 = '0; req_exp1 = '0;
    req_mod0 = 8'd5; req_mod1 = 8'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      do_job(vt[i].port, vt[i].base, vt[i].exp, vt[i].mod, vt[i].data, vt[i].err);

    for (int i = 0; i < 6; i++) begin
      logic p;
      logic [N_W-1:0] b, n;
      logic [E_W-1:0] e;
      p = 1'($urandom_range(1, 0));
      b = N_W'($urandom_range(255, 0));
      e = E_W'($urandom_range(511, 0));
      n = N_W'($urandom_range(255, 2));
      do_job(p, b, e, n, ref_pow(int'(b), int'(e), int'(n)), 1'b0);
    end

    // Contention from reset: expect grants 0,1,0,1.
    do_reset();
    sb.push_back('{id: 1'b0, data: 8'd13, err: 1'b0});
    sb.push_back('{id: 1'b1, data: 8'd7,  err: 1'b0});
    sb.push_back('{id: 1'b0, data: 8'd12, err: 1'b0});
    sb.push_back('{id: 1'b1, data: 8'd1,  err: 1'b0});
    drive(1'b0, 8'd7, 9'd3, 8'd33);
    drive(1'b1, 8'd13, 9'd7, 8'd33);
    begin
      int i0, i1;
      logic a0, a1;
      i0 = 0; i1 = 0;
      for (int c = 0; c < 200 && (i0 < 2 || i1 < 2); c++) begin
        @(negedge clk);
        a0 = req_valid[0] & req_ready[0];
        a1 = req_valid[1] & req_ready[1];
        @(posedge clk);
        #1;
        if (a0) begin
          i0++;
          if (i0 < 2) drive(1'b0, 8'd3, 9'd7, 8'd15); else req_valid[0] = 1'b0;
        end
        if (a1) begin
          i1++;
          if (i1 < 2) drive(1'b1, 8'd5, 9'd0, 8'd15); else req_valid[1] = 1'b0;
        end
      end
      req_valid = 2'b00;
    end
    wait_empty("rr_responses");
    nv = grants.size();
    chk("rr_grant_count", nv, 32'd4);
    for (int g = 0; g < 4; g++)
      chk("rr_grant_order", (g < nv) ? {31'd0, grants[g]} : 32'd9, g % 2);

    // Hold in DONE with rsp_ready low; port 1 waits without being granted.
    do_reset();
    rsp_ready = 1'b0;
    sb.push_back('{id: 1'b0, data: 8'd12, err: 1'b0});
    sb.push_back('{id: 1'b1, data: 8'd7,  err: 1'b0});
    drive(1'b0, 8'd3, 9'd7, 8'd15);
    drive(1'b1, 8'd13, 9'd7, 8'd33);
    wait_acc(1'b0, ok);
    chk("hold_first_grant_p0", {31'd0, ok}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_data", {24'd0, rsp_data}, 32'd12);
      chk("hold_no_grant", {30'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_acc(1'b1, ok);
    chk("hold_then_p1", {31'd0, ok}, 32'd1);
    wait_empty("hold_responses");

    // Reset pulsed at T+4 aborts the job.
    sb.push_back('{id: 1'b0, data: 8'd13, err: 1'b0});
    drive(1'b0, 8'd7, 9'd3, 8'd33);
    wait_acc(1'b0, ok);
    chk("abort_accepted", {31'd0, ok}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        if (rsp_valid) seen++;
      end
      chk("abort_no_rsp", seen, 32'd0);
    end
    @(posedge clk);
    #1;
    do_job(1'b1, 8'd3, 9'd7, 8'd15, 8'd12, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
